mult_div_unit: RTL and testbench

Iterative HI/LO multiply/divide unit for the pipelined MIPS core, sitting in the execute stage directly downstream of the forwarding multiplexers that select the rs/rt operands. It runs MULT, MULTU, DIV and DIVU as a multi-cycle operation and holds the results in the architectural HI/LO registers. It also services MTHI/MTLO writes. It raises `busy` so the hazard logic can stall MFHI/MFLO and any new multiply/divide until the result has been committed.

---
 rtl/mult_div_unit.sv | 164 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: MULT/MULTU/DIV/DIVU plus MTHI/MTLO writes.
// Define MDU_FAST_MUL_EN to issue multiplies through a single-cycle 64-bit '*' operator.
module mult_div_unit #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [Width-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [Width-1:0] hi,
  output logic [Width-1:0] lo
);
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StFin  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               div_q, div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [Width-1:0]   mag_a_q, mag_a_d;
  logic [Width-1:0]   mag_b_q, mag_b_d;
  logic [2*Width-1:0] acc_q, acc_d;
  logic [Width-1:0]   hi_q, hi_d;
  logic [Width-1:0]   lo_q, lo_d;

  logic               is_signed, launch, div_fit;
  logic [Width-1:0]   abs_a, abs_b;
  logic [Width:0]     mul_sum;
  logic [Width:0]     div_shift;
  logic [Width-1:0]   div_diff;
  logic [2*Width-1:0] prod_fix;
  logic [Width-1:0]   quo_fix, rem_fix, a_orig;

  assign is_signed = ~op[0];
  assign abs_a     = (is_signed && a[Width-1]) ? -a : a;
  assign abs_b     = (is_signed && b[Width-1]) ? -b : b;
  // FIN shares the launch path so a stalled start can issue back-to-back.
  assign launch    = start && !flush && (state_q == StIdle || state_q == StFin);

  // Multiply: add the current multiplier bit (LSB first), then shift the accumulator right.
  assign mul_sum   = {1'b0, acc_q[2*Width-1:Width]} + (mag_b_q[cnt_q] ? {1'b0, mag_a_q} : '0);
  // Divide: remainder lives in the upper half, quotient shifts into the lower half; ~cnt = 31-cnt.
  assign div_shift = {acc_q[2*Width-1:Width], mag_a_q[~cnt_q]};
  assign div_fit   = div_shift >= {1'b0, mag_b_q};
  assign div_diff  = div_shift[Width-1:0] - mag_b_q;

  assign prod_fix  = neg_res_q ? -acc_q : acc_q;
  assign quo_fix   = neg_res_q ? -acc_q[Width-1:0] : acc_q[Width-1:0];
  assign rem_fix   = neg_rem_q ? -acc_q[2*Width-1:Width] : acc_q[2*Width-1:Width];
  assign a_orig    = neg_rem_q ? -mag_a_q : mag_a_q;

`ifdef MDU_FAST_MUL_EN
  logic [2*Width-1:0] fast_prod;
  // Low 64 bits of the extended product are correct for both signed and unsigned operands.
  assign fast_prod = {{Width{is_signed & a[Width-1]}}, a} * {{Width{is_signed & b[Width-1]}}, b};
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      StIdle: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
      end
      StRun: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 5'd1;
          if (div_q) begin
            acc_d = div_fit ? {div_diff, acc_q[Width-2:0], 1'b1}
                            : {div_shift[Width-1:0], acc_q[Width-2:0], 1'b0};
          end else begin
            acc_d = {mul_sum, acc_q[Width-1:1]};
          end
          if (cnt_q == 5'd31) state_d = StFin;
        end
      end
      StFin: begin
        state_d = StIdle;
        if (!flush) begin
          if (!div_q) begin
            {hi_d, lo_d} = prod_fix;
          end else if (mag_b_q == '0) begin
            hi_d = a_orig;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (launch) begin
      div_d     = op[1];
      mag_a_d   = abs_a;
      mag_b_d   = abs_b;
      neg_res_d = is_signed && (a[Width-1] ^ b[Width-1]);
      neg_rem_d = is_signed && a[Width-1];
      acc_d     = '0;
      cnt_d     = '0;
      state_d   = StRun;
`ifdef MDU_FAST_MUL_EN
      if (!op[1]) begin
        acc_d     = fast_prod;
        neg_res_d = 1'b0;
        state_d   = StFin;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      mag_a_q   <= mag_a_d;
      mag_b_q   <= mag_b_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StFin);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit; honours MDU_FAST_MUL_EN for multiply latency.
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        start = 1'b0, flush = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

`ifdef MDU_FAST_MUL_EN
  localparam int MulLat = 1;
`else
  localparam int MulLat = 33;
`endif

  mult_div_unit #(.Width(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Drive one start pulse; returns 1ns after the sampling edge E0.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count busy and done cycles until the unit goes idle (bounded).
  task automatic wait_idle(output int nb, output int nd);
    nb = 0; nd = 0;
    while (busy && nb < 200) begin
      nb++;
      if (done) nd++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_multu_max();
    int nb, nd;
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(nb, nd);
    checks++; if (nb != MulLat) begin errors++; $display("FAIL multu_busy got %0d want %0d", nb, MulLat); end
    checks++; if (nd != 1) begin errors++; $display("FAIL multu_done got %0d want 1", nd); end
    checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got %h want fffffffe", hi); end
    checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got %h want 00000001", lo); end
  endtask

  task automatic test_vectors();
    logic [1:0]  vop [8] = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b11, 2'b10, 2'b11, 2'b10};
    logic [31:0] va  [8] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFF9, 32'h8000_0000,
                             32'd100, 32'hFFFF_FFF9, 32'd100, 32'd7};
    logic [31:0] vb  [8] = '{32'd7, 32'd2, 32'd2, 32'hFFFF_FFFF,
                             32'd0, 32'd0, 32'd7, 32'hFFFF_FFFE};
    logic [31:0] vhi [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,
                             32'd100, 32'hFFFF_FFF9, 32'd2, 32'd1};
    logic [31:0] vlo [8] = '{32'hFFFF_FFEB, 32'h0000_0000, 32'hFFFF_FFFD, 32'h8000_0000,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd14, 32'hFFFF_FFFD};
    int nb, nd, lat;
    for (int i = 0; i < 8; i++) begin
      issue(vop[i], va[i], vb[i]);
      wait_idle(nb, nd);
      lat = vop[i][1] ? 33 : MulLat;
      checks++;
      if (nb != lat || nd != 1) begin
        errors++; $display("FAIL vec%0d_timing busy %0d done %0d want %0d/1", i, nb, nd, lat);
      end
      checks++;
      if (hi !== vhi[i] || lo !== vlo[i]) begin
        errors++; $display("FAIL vec%0d_result got %h_%h want %h_%h", i, hi, lo, vhi[i], vlo[i]);
      end
    end
  endtask

  task automatic test_mthi_mtlo();
    wdata = 32'h1234; hi_we = 1'b1;
    @(posedge clk); #1;
    hi_we = 1'b0;
    checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL mthi got %h want 1234", hi); end
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL mthi_lo got %h want fffffffd", lo); end
    wdata = 32'hCAFE; hi_we = 1'b1; lo_we = 1'b1;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    checks++;
    if (hi !== 32'hCAFE || lo !== 32'hCAFE) begin
      errors++; $display("FAIL mthi_mtlo got %h_%h want cafe_cafe", hi, lo);
    end
  endtask

  task automatic test_busy_side_traffic();
    int nb, nd;
    issue(2'b11, 32'd100, 32'd7);
    @(posedge clk); #1;
    wdata = 32'h1234; hi_we = 1'b1; lo_we = 1'b1;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    checks++;
    if (hi !== 32'hCAFE || lo !== 32'hCAFE) begin
      errors++; $display("FAIL busy_write got %h_%h want cafe_cafe", hi, lo);
    end
    start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(nb, nd);
    checks++;
    if (hi !== 32'd2 || lo !== 32'd14) begin
      errors++; $display("FAIL busy_start got %h_%h want 2_14", hi, lo);
    end
  endtask

  task automatic test_flush();
    int nd = 0;
    wdata = 32'hAAAA; hi_we = 1'b1;
    @(posedge clk); #1;
    hi_we = 1'b0; wdata = 32'hBBBB; lo_we = 1'b1;
    @(posedge clk); #1;
    lo_we = 1'b0;
    issue(2'b11, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", busy); end
    for (int i = 0; i < 40; i++) begin
      if (done) nd++;
      @(posedge clk); #1;
    end
    checks++; if (nd != 0) begin errors++; $display("FAIL flush_done got %0d want 0", nd); end
    checks++;
    if (hi !== 32'hAAAA || lo !== 32'hBBBB) begin
      errors++; $display("FAIL flush_hilo got %h_%h want aaaa_bbbb", hi, lo);
    end
    start = 1'b1; flush = 1'b1; op = 2'b11;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_start got %b want 0", busy); end
  endtask

  task automatic test_start_with_mthi();
    int nb, nd;
    wdata = 32'hBEEF; hi_we = 1'b1;
    issue(2'b01, 32'd6, 32'd7);
    hi_we = 1'b0;
    checks++; if (hi !== 32'hBEEF) begin errors++; $display("FAIL start_mthi got %h want beef", hi); end
    wait_idle(nb, nd);
    checks++;
    if (hi !== 32'd0 || lo !== 32'd42) begin
      errors++; $display("FAIL start_mthi_res got %h_%h want 0_42", hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int k = 0;
    int nb, nd;
    issue(2'b11, 32'd100, 32'd7);
    while (!done && k < 60) begin
      k++;
      @(posedge clk); #1;
    end
    checks++; if (k != 32) begin errors++; $display("FAIL b2b_done_at got %0d want 32", k); end
    issue(2'b01, 32'd3, 32'd5);
    checks++;
    if (hi !== 32'd2 || lo !== 32'd14 || busy !== 1'b1) begin
      errors++; $display("FAIL b2b_first got %h_%h busy %b want 2_14 busy 1", hi, lo, busy);
    end
    wait_idle(nb, nd);
    checks++;
    if (nb != MulLat || hi !== 32'd0 || lo !== 32'd15) begin
      errors++; $display("FAIL b2b_second got %h_%h lat %0d want 0_15 lat %0d", hi, lo, nb, MulLat);
    end
  endtask

  task automatic test_reset_mid_op();
    wdata = 32'h77; hi_we = 1'b1; lo_we = 1'b1;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    issue(2'b10, 32'd50, 32'd3);
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid got %h_%h busy %b want 0_0 busy 0", hi, lo, busy);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_multu_max();
    test_vectors();
    test_mthi_mtlo();
    test_busy_side_traffic();
    test_flush();
    test_start_with_mthi();
    test_back_to_back();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
